// File: rtl/regfile_wb_ctrl.sv
// Write-port controller for the 32x32 register file: zero-fills x1..x31 after
// reset, then round-robin arbitrates the ALU and memory writeback requesters.
module regfile_wb_ctrl #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic [4:0]  rd_addr,
  output logic [31:0] w_data,
  output logic        w_en,
  output logic        busy
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e      state_q, state_d;
  logic [4:0]  clr_cnt_q, clr_cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic        w_en_q, w_en_d;
  logic        busy_q, busy_d;
  logic        alu_gnt_s, mem_gnt_s;

  // Grant: under contention the requester not served last wins.
  always_comb begin
    alu_gnt_s = 1'b0;
    mem_gnt_s = 1'b0;
    if (state_q == ST_RUN) begin
      if (alu_valid && mem_valid) begin
        if (last_grant_q) begin
          alu_gnt_s = 1'b1;
        end else begin
          mem_gnt_s = 1'b1;
        end
      end else begin
        alu_gnt_s = alu_valid;
        mem_gnt_s = mem_valid;
      end
    end else begin
      alu_gnt_s = 1'b0;
      mem_gnt_s = 1'b0;
    end
  end

  // Next state: clear sweep or accepted request drives the write port.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    last_grant_d = last_grant_q;
    rd_addr_d    = rd_addr_q;
    w_data_d     = w_data_q;
    w_en_d       = 1'b0;
    busy_d       = busy_q;
    case (state_q)
      ST_CLEAR: begin
        rd_addr_d = clr_cnt_q;
        w_data_d  = 32'd0;
        w_en_d    = 1'b1;
        clr_cnt_d = clr_cnt_q + 5'd1;
        if (clr_cnt_q == 5'd31) begin
          state_d = ST_RUN;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        // An x0 request is consumed without raising the write enable.
        if (alu_gnt_s) begin
          rd_addr_d    = alu_rd;
          w_data_d     = alu_data;
          w_en_d       = (alu_rd != 5'd0);
          last_grant_d = 1'b0;
        end else if (mem_gnt_s) begin
          rd_addr_d    = mem_rd;
          w_data_d     = mem_data;
          w_en_d       = (mem_rd != 5'd0);
          last_grant_d = 1'b1;
        end else begin
          w_en_d = 1'b0;
        end
      end
      default: begin
        state_d = RESET_STATE;
        w_en_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over any transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RESET_STATE;
      clr_cnt_q    <= 5'd1;
      last_grant_q <= 1'b0;
      rd_addr_q    <= 5'd0;
      w_data_q     <= 32'd0;
      w_en_q       <= 1'b0;
      busy_q       <= CLEAR_ON_RESET;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_grant_q <= last_grant_d;
      rd_addr_q    <= rd_addr_d;
      w_data_q     <= w_data_d;
      w_en_q       <= w_en_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_ready = alu_gnt_s;
  assign mem_ready = mem_gnt_s;
  assign rd_addr   = rd_addr_q;
  assign w_data    = w_data_q;
  assign w_en      = w_en_q;
  assign busy      = busy_q;

endmodule
